// File: rtl/fila_pkg.sv
// Shared types and constants for the FILA queue and its reader.
package fila_pkg;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, PRESENT, DONE} fila_leitor_state_t;

   localparam int unsigned FILA_DEPTH  = 8;
   localparam int unsigned FILA_DATA_W = 8;
   localparam int unsigned FILA_RD_LAT = 2;

endpackage

// File: rtl/fila_wait_cnt.sv
// Loadable down-counter shared by the read-latency wait and the consumer timeout.
// o_zero is look-ahead: it is high when the current decrement brings the count to zero.
module fila_wait_cnt #(
   parameter int unsigned W = 5
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt <= W'(1));

endmodule

// File: rtl/fila_leitor.sv
// FILA reader: pops bytes, waits the queue read latency and hands them out on valid/ready.
// Define FILA_LEITOR_TIMEOUT_EN to drop a byte the consumer ignores for TIMEOUT cycles.
module fila_leitor
   import fila_pkg::*;
#(
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned RD_LAT  = FILA_RD_LAT,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                   clock_10KHz,
   input  logic                   reset,
   input  logic [LEN_W-1:0]       q_len_in,
   input  logic [FILA_DATA_W-1:0] q_data_in,
   output logic                   q_dequeue_out,
   input  logic                   start_in,
   input  logic [CNT_W-1:0]       burst_in,
   output logic                   busy_out,
   output logic                   done_out,
   output logic [CNT_W-1:0]       drained_out,
   output logic [FILA_DATA_W-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   timeout_out
);

   localparam int unsigned WAIT_MAX = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
   localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] DRAIN_MAX = '1;

   fila_leitor_state_t     r_state, w_state_nx;
   logic [CNT_W-1:0]       r_remaining, r_drained, w_drained_inc;
   logic                   r_counted;
   logic [FILA_DATA_W-1:0] r_data;
   logic                   w_start, w_capture, w_accept;
   logic                   w_cnt_load, w_cnt_dec, w_cnt_zero;
   logic [WAIT_W-1:0]      w_cnt_val;
`ifdef FILA_LEITOR_TIMEOUT_EN
   logic                   w_abort;
   logic                   r_timeout;
`endif

   assign w_drained_inc = r_drained + 1'b1;

   always_comb begin
      w_state_nx    = r_state;
      w_start       = 1'b0;
      w_capture     = 1'b0;
      w_accept      = 1'b0;
      w_cnt_load    = 1'b0;
      w_cnt_dec     = 1'b0;
      w_cnt_val     = WAIT_W'(RD_LAT);
      q_dequeue_out = 1'b0;
`ifdef FILA_LEITOR_TIMEOUT_EN
      w_abort       = 1'b0;
`endif
      unique case (r_state)
         IDLE: begin
            if (start_in) begin
               w_start    = 1'b1;
               w_state_nx = REQ;
            end
         end
         REQ: begin
            if (q_len_in == '0) begin
               w_state_nx = DONE;
            end else begin
               q_dequeue_out = 1'b1;
               w_cnt_load    = 1'b1;
               w_state_nx    = WAIT;
            end
         end
         WAIT: begin
            w_cnt_dec = 1'b1;
            if (w_cnt_zero) begin
               w_capture  = 1'b1;
               w_state_nx = PRESENT;
`ifdef FILA_LEITOR_TIMEOUT_EN
               // Same counter is re-armed as the consumer timeout.
               w_cnt_load = 1'b1;
               w_cnt_val  = WAIT_W'(TIMEOUT);
`endif
            end
         end
         PRESENT: begin
            if (out_ready) begin
               w_accept = 1'b1;
               if ((r_counted && (r_remaining == CNT_W'(1))) || (w_drained_inc == DRAIN_MAX)) begin
                  w_state_nx = DONE;
               end else begin
                  w_state_nx = REQ;
               end
            end
`ifdef FILA_LEITOR_TIMEOUT_EN
            else begin
               w_cnt_dec = 1'b1;
               if (w_cnt_zero) begin
                  w_abort    = 1'b1;
                  w_state_nx = DONE;
               end
            end
`endif
         end
         DONE:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock_10KHz or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_counted   <= 1'b0;
         r_drained   <= '0;
         r_data      <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_start) begin
            r_remaining <= burst_in;
            r_counted   <= (burst_in != '0);
            r_drained   <= '0;
         end
         if (w_capture) begin
            r_data <= q_data_in;
         end
         if (w_accept) begin
            r_drained <= w_drained_inc;
            if (r_counted) begin
               r_remaining <= r_remaining - 1'b1;
            end
         end
      end
   end

`ifdef FILA_LEITOR_TIMEOUT_EN
   always_ff @(posedge clock_10KHz or posedge reset) begin
      if (reset) begin
         r_timeout <= 1'b0;
      end else if (w_start) begin
         r_timeout <= 1'b0;
      end else if (w_abort) begin
         r_timeout <= 1'b1;
      end
   end
   assign timeout_out = r_timeout;
`else
   assign timeout_out = 1'b0;
`endif

   fila_wait_cnt #(
      .W (WAIT_W)
   ) u_wait_cnt (
      .i_clk      (clock_10KHz),
      .i_rst      (reset),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   assign out_valid   = (r_state == PRESENT);
   assign out_data    = r_data;
   assign done_out    = (r_state == DONE);
   assign busy_out    = (r_state == REQ) || (r_state == WAIT) || (r_state == PRESENT);
   assign drained_out = r_drained;

endmodule

// File: tb/tb_fila_leitor.sv
// Bench for fila_leitor: a FILA queue model with exact read latency, table-driven drains,
// hand-written corner sequences and randomized drains checked against a reference queue.
module tb_fila_leitor;

   localparam int LEN_W   = 4;
   localparam int CNT_W   = 4;
   localparam int RD_LAT  = 2;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [LEN_W-1:0] q_len_in = '0;
   logic [7:0]       q_data_in = '0;
   logic             q_dequeue_out;
   logic             start_in = 1'b0;
   logic [CNT_W-1:0] burst_in = '0;
   logic             busy_out, done_out, out_valid, timeout_out;
   logic [CNT_W-1:0] drained_out;
   logic [7:0]       out_data;
   logic             out_ready = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
   int low_run = 0;
   int deq_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int done_base = 0;
   int start_cyc = 0;

   logic [7:0] fq[$];    // contents of the modelled FILA
   logic [7:0] mq[$];    // reference: bytes the consumer should still receive, in order
   logic [7:0] rx[$];    // bytes actually handed over
   int         deq_cyc[$];
   logic       deq_seen = 1'b0;
   logic       pipe_v[RD_LAT];
   logic [7:0] pipe_d[RD_LAT];
   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [7:0] prev_data = '0;

   typedef struct {
      int         len;
      logic [7:0] first;
      int         burst;
      int         exp_n;
   } vec_t;
   vec_t tbl[7];

   always #5 clk = ~clk;

   fila_leitor #(
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W),
      .RD_LAT  (RD_LAT),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock_10KHz   (clk),
      .reset         (rst),
      .q_len_in      (q_len_in),
      .q_data_in     (q_data_in),
      .q_dequeue_out (q_dequeue_out),
      .start_in      (start_in),
      .burst_in      (burst_in),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .drained_out   (drained_out),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .timeout_out   (timeout_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_count(input int len, input int burst);
      int n;
      n = len;
      if (burst != 0 && burst < n) n = burst;
      if (n > 15) n = 15;
      return n;
   endfunction

   // Consumer-side monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      deq_seen = q_dequeue_out;
      if (rst) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (prev_valid && !prev_ready && !timeout_out) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev_data));
         end
         if (q_dequeue_out) begin
            deq_cnt++;
            deq_cyc.push_back(cyc);
         end
         if (done_out) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (out_valid && out_ready) rx.push_back(out_data);
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
      end
   end

   // FILA model: a popped byte appears on q_data_in exactly RD_LAT cycles after the pulse.
   always @(posedge clk) begin
      #1;
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pipe_v[i] = pipe_v[i-1];
         pipe_d[i] = pipe_d[i-1];
      end
      pipe_v[0] = 1'b0;
      pipe_d[0] = '0;
      if (deq_seen) begin
         chk("deq_nonempty", 32'(fq.size() != 0), 32'd1);
         if (fq.size() != 0) begin
            pipe_v[0] = 1'b1;
            pipe_d[0] = fq.pop_front();
         end
      end
      q_len_in  = LEN_W'(fq.size());
      q_data_in = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 8'($urandom);
   end

   always @(posedge clk) begin
      #1;
      if (ready_mode == 0) begin
         out_ready = 1'b1;
      end else if (ready_mode == 2) begin
         out_ready = 1'b0;
      end else if (low_run >= 6 || $urandom_range(0, 3) != 0) begin
         out_ready = 1'b1;
         low_run   = 0;
      end else begin
         out_ready = 1'b0;
         low_run++;
      end
   end

   task automatic load_q(input int n, input logic [7:0] first, input logic [7:0] step);
      fq.delete();
      mq.delete();
      for (int j = 0; j < n; j++) begin
         fq.push_back(8'(first + 8'(j) * step));
         mq.push_back(8'(first + 8'(j) * step));
      end
      q_len_in = LEN_W'(fq.size());
   endtask

   task automatic load_rand(input int n);
      logic [7:0] b;
      fq.delete();
      mq.delete();
      for (int j = 0; j < n; j++) begin
         b = 8'($urandom);
         fq.push_back(b);
         mq.push_back(b);
      end
      q_len_in = LEN_W'(fq.size());
   endtask

   task automatic start_drain(input int burst);
      rx.delete();
      deq_cyc.delete();
      done_base = done_cnt;
      @(posedge clk);
      #2;
      start_in  = 1'b1;
      burst_in  = CNT_W'(burst);
      start_cyc = cyc + 1;
      @(posedge clk);
      #2;
      start_in = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int k = 0; k < budget && done_cnt == done_base; k++) begin
         @(negedge clk);
         #1;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt != done_base), 32'd1);
      repeat (2) @(negedge clk);
      #1;
      chk({tag, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
      chk({tag, "_busy_low"}, 32'(busy_out), 32'd0);
   endtask

   task automatic check_result(input string tag, input int exp_n);
      logic [7:0] e;
      chk({tag, "_drained"}, 32'(drained_out), 32'(exp_n));
      chk({tag, "_count"}, 32'(rx.size()), 32'(exp_n));
      chk({tag, "_deqs"}, 32'(deq_cyc.size()), 32'(exp_n));
      for (int j = 0; j < exp_n; j++) begin
         e = mq.pop_front();
         if (j < rx.size()) chk({tag, "_byte"}, 32'(rx[j]), 32'(e));
      end
      chk({tag, "_left"}, 32'(q_len_in), 32'(mq.size()));
      chk({tag, "_timeout"}, 32'(timeout_out), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      int n;
      int b;
      for (int i = 0; i < RD_LAT; i++) begin
         pipe_v[i] = 1'b0;
         pipe_d[i] = '0;
      end
      tbl[0] = '{len: 3, first: 8'h40, burst: 2, exp_n: 2};
      tbl[1] = '{len: 8, first: 8'h00, burst: 0, exp_n: 8};
      tbl[2] = '{len: 0, first: 8'h00, burst: 5, exp_n: 0};
      tbl[3] = '{len: 5, first: 8'h70, burst: 7, exp_n: 5};
      tbl[4] = '{len: 8, first: 8'hF8, burst: 8, exp_n: 8};
      tbl[5] = '{len: 4, first: 8'h91, burst: 1, exp_n: 1};
      tbl[6] = '{len: 6, first: 8'h3C, burst: 3, exp_n: 3};

      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", 32'({q_dequeue_out, busy_out, done_out, out_valid, timeout_out,
                               drained_out, out_data}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("idle_outputs", 32'({q_dequeue_out, busy_out, done_out, out_valid, timeout_out,
                              drained_out, out_data}), 32'd0);

      // Burst of 2 from A1,B2,C3 with a zero-wait consumer.
      load_q(3, 8'hA1, 8'h11);
      start_drain(2);
      wait_done("t1", 100);
      check_result("t1", 2);
      if (deq_cyc.size() >= 2) chk("t1_pitch", 32'(deq_cyc[1] - deq_cyc[0]), 32'd4);

      // Empty queue: no pulse, done two cycles after start.
      load_q(0, 8'h00, 8'h00);
      start_drain(0);
      wait_done("t3", 50);
      check_result("t3", 0);
      chk("t3_done_lat", 32'(done_cyc - start_cyc), 32'd2);

      for (int i = 0; i < 7; i++) begin
         load_q(tbl[i].len, tbl[i].first, 8'h01);
         start_drain(tbl[i].burst);
         wait_done($sformatf("tbl%0d", i), 200);
         check_result($sformatf("tbl%0d", i), tbl[i].exp_n);
      end

      // Consumer stalls for 5 cycles while a byte is presented.
      ready_mode = 2;
      load_q(2, 8'h5A, 8'h01);
      repeat (2) @(negedge clk);
      start_drain(1);
      for (int k = 0; k < 20 && !out_valid; k++) begin
         @(negedge clk);
         #1;
      end
      chk("t4_valid_seen", 32'(out_valid), 32'd1);
      n0 = deq_cnt;
      for (int k = 0; k < 5; k++) begin
         chk("t4_stall_valid", 32'(out_valid), 32'd1);
         chk("t4_stall_data", 32'(out_data), 32'h5A);
         @(negedge clk);
         #1;
      end
      chk("t4_no_deq", 32'(deq_cnt - n0), 32'd0);
      ready_mode = 0;
      wait_done("t4", 50);
      check_result("t4", 1);

      // Reset while waiting for the first popped byte: that byte is lost.
      load_q(4, 8'h30, 8'h01);
      start_drain(0);
      n0 = deq_cnt;
      for (int k = 0; k < 20 && deq_cnt == n0; k++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t5_reset_outputs", 32'({q_dequeue_out, busy_out, done_out, out_valid, timeout_out,
                                  drained_out, out_data}), 32'd0);
      void'(mq.pop_front());
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      start_drain(0);
      wait_done("t5", 200);
      check_result("t5", 3);

`ifdef FILA_LEITOR_TIMEOUT_EN
      // Consumer never ready: byte dropped after TIMEOUT cycles.
      ready_mode = 2;
      load_q(2, 8'hE0, 8'h01);
      repeat (2) @(negedge clk);
      start_drain(0);
      wait_done("t6", 100);
      chk("t6_timeout", 32'(timeout_out), 32'd1);
      chk("t6_drained", 32'(drained_out), 32'd0);
      chk("t6_count", 32'(rx.size()), 32'd0);
      void'(mq.pop_front());
      ready_mode = 0;
      repeat (2) @(negedge clk);
      start_drain(0);
      wait_done("t6b", 100);
      check_result("t6b", 1);
`endif

      // Randomized drains with a randomly stalling consumer.
      ready_mode = 1;
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(0, 8);
         b = $urandom_range(0, 10);
         load_rand(n);
         start_drain(b);
         wait_done($sformatf("rnd%0d", it), 400);
         check_result($sformatf("rnd%0d", it), ref_count(n, b));
      end
      ready_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
